// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FUNCT3 access codes and one-hot FSM states.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'b0001,
        ST_LOAD_WAIT  = 4'b0010,
        ST_STORE_WAIT = 4'b0100,
        ST_RESP       = 4'b1000
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: alignment check, store byte enables / lane replication,
// load lane selection with sign or zero extension.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic        is_store,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic        ok,
    output logic [3:0]  be,
    output logic [31:0] wlane,
    output logic [31:0] rext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Unsigned variants exist only for loads; stores accept 000/001/010 alone.
    always_comb begin
        ok = 1'b0;
        case (funct3)
            F3_LB:   ok = 1'b1;
            F3_LH:   ok = ~offset[0];
            F3_LW:   ok = (offset == 2'b00);
            F3_LBU:  ok = ~is_store;
            F3_LHU:  ok = ~is_store & ~offset[0];
            default: ok = 1'b0;
        endcase
    end

    always_comb begin
        case (funct3)
            F3_SB: begin
                be    = 4'b0001 << offset;
                wlane = {4{wdata[7:0]}};
            end
            F3_SH: begin
                be    = 4'b0011 << {offset[1], 1'b0};
                wlane = {2{wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata;
            end
        endcase
    end

    always_comb begin
        case (offset)
            2'b00:   rbyte = rword[7:0];
            2'b01:   rbyte = rword[15:8];
            2'b10:   rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        rhalf = offset[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        case (funct3)
            F3_LB:   rext = {{24{rbyte[7]}}, rbyte};
            F3_LH:   rext = {{16{rhalf[15]}}, rhalf};
            F3_LBU:  rext = {24'd0, rbyte};
            F3_LHU:  rext = {16'd0, rhalf};
            default: rext = rword;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-side load/store unit: req/ack word bus master with a one-entry posted-store slot,
// alignment checking and a bus timeout.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          DATA_REQ,
    input  logic          DATA_WRITE_ENABLE,
    input  logic [2:0]    FUNCT3,
    input  logic [AW-1:0] ADDR,
    input  logic [31:0]   WDATA,
    output logic          DATA_VALID,
    output logic [31:0]   RDATA,
    output logic          BUSY,
    output logic          MISALIGNED,
    output logic          BUS_ERR,
    output logic          OVERRUN,
    output logic          MEM_REQ,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [3:0]    MEM_BE,
    output logic [31:0]   MEM_WDATA,
    input  logic          MEM_ACK,
    input  logic [31:0]   MEM_RDATA
);

    localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit             TMO_EN   = (TIMEOUT != 0);

    lsu_state_e    state_reg, state_next;
    logic          pend_valid_reg, pend_valid_next;
    logic [AW-1:0] pend_addr_reg, pend_addr_next;
    logic [31:0]   pend_data_reg, pend_data_next;
    logic [2:0]    pend_f3_reg, pend_f3_next;
    logic [2:0]    ld_f3_reg, ld_f3_next;
    logic [1:0]    ld_off_reg, ld_off_next;
    logic [AW-1:0] bus_addr_reg, bus_addr_next;
    logic [3:0]    bus_be_reg, bus_be_next;
    logic [31:0]   bus_wdata_reg, bus_wdata_next;
    logic [31:0]   rdata_reg, rdata_next;
    logic          mis_reg, mis_next;
    logic          err_reg, err_next;
    logic          overrun_reg, overrun_next;
    logic [CW-1:0] tmo_cnt_reg, tmo_cnt_next;

    logic          is_idle, timed_out;
    logic          sel_store;
    logic [2:0]    sel_f3;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic          align_ok;
    logic [3:0]    align_be;
    logic [31:0]   align_wlane, align_rext;

    assign is_idle   = (state_reg == ST_IDLE);
    assign timed_out = TMO_EN && (tmo_cnt_reg == TMO_LAST);

    // A pending store always beats a fresh pulse, which beats a load.
    assign sel_store = pend_valid_reg | DATA_WRITE_ENABLE;
    assign sel_f3    = pend_valid_reg ? pend_f3_reg   : FUNCT3;
    assign sel_addr  = pend_valid_reg ? pend_addr_reg : ADDR;
    assign sel_wdata = pend_valid_reg ? pend_data_reg : WDATA;

    load_store_unit_align u_align (
        .funct3   (is_idle ? sel_f3 : ld_f3_reg),
        .offset   (is_idle ? sel_addr[1:0] : ld_off_reg),
        .is_store (is_idle & sel_store),
        .wdata    (sel_wdata),
        .rword    (MEM_RDATA),
        .ok       (align_ok),
        .be       (align_be),
        .wlane    (align_wlane),
        .rext     (align_rext)
    );

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_reg      <= ST_IDLE;
            pend_valid_reg <= 1'b0;
            pend_addr_reg  <= '0;
            pend_data_reg  <= '0;
            pend_f3_reg    <= '0;
            ld_f3_reg      <= '0;
            ld_off_reg     <= '0;
            bus_addr_reg   <= '0;
            bus_be_reg     <= '0;
            bus_wdata_reg  <= '0;
            rdata_reg      <= '0;
            mis_reg        <= 1'b0;
            err_reg        <= 1'b0;
            overrun_reg    <= 1'b0;
            tmo_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            pend_valid_reg <= pend_valid_next;
            pend_addr_reg  <= pend_addr_next;
            pend_data_reg  <= pend_data_next;
            pend_f3_reg    <= pend_f3_next;
            ld_f3_reg      <= ld_f3_next;
            ld_off_reg     <= ld_off_next;
            bus_addr_reg   <= bus_addr_next;
            bus_be_reg     <= bus_be_next;
            bus_wdata_reg  <= bus_wdata_next;
            rdata_reg      <= rdata_next;
            mis_reg        <= mis_next;
            err_reg        <= err_next;
            overrun_reg    <= overrun_next;
            tmo_cnt_reg    <= tmo_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pend_valid_next = pend_valid_reg;
        pend_addr_next  = pend_addr_reg;
        pend_data_next  = pend_data_reg;
        pend_f3_next    = pend_f3_reg;
        ld_f3_next      = ld_f3_reg;
        ld_off_next     = ld_off_reg;
        bus_addr_next   = bus_addr_reg;
        bus_be_next     = bus_be_reg;
        bus_wdata_next  = bus_wdata_reg;
        rdata_next      = rdata_reg;
        mis_next        = 1'b0;
        err_next        = 1'b0;
        overrun_next    = overrun_reg;
        tmo_cnt_next    = tmo_cnt_reg;

        // Pending slot: drained in IDLE, refilled by any pulse not launched directly.
        if (is_idle && pend_valid_reg)
            pend_valid_next = 1'b0;
        if (DATA_WRITE_ENABLE && !(is_idle && !pend_valid_reg)) begin
            if (pend_valid_reg && !is_idle) begin
                overrun_next = 1'b1;
            end else begin
                pend_valid_next = 1'b1;
                pend_addr_next  = ADDR;
                pend_data_next  = WDATA;
                pend_f3_next    = FUNCT3;
            end
        end

        case (state_reg)
            ST_IDLE: begin
                if (sel_store || DATA_REQ) begin
                    if (!align_ok) begin
                        mis_next = 1'b1;
                        if (!sel_store) begin
                            rdata_next = '0;
                            state_next = ST_RESP;
                        end
                    end else begin
                        state_next     = sel_store ? ST_STORE_WAIT : ST_LOAD_WAIT;
                        bus_addr_next  = {sel_addr[AW-1:2], 2'b00};
                        bus_be_next    = sel_store ? align_be : 4'b1111;
                        bus_wdata_next = sel_store ? align_wlane : 32'd0;
                        ld_f3_next     = sel_f3;
                        ld_off_next    = sel_addr[1:0];
                        tmo_cnt_next   = '0;
                    end
                end
            end
            ST_LOAD_WAIT: begin
                if (MEM_ACK) begin
                    rdata_next = align_rext;
                    state_next = ST_RESP;
                end else if (timed_out) begin
                    rdata_next = '0;
                    err_next   = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            ST_STORE_WAIT: begin
                if (MEM_ACK) begin
                    state_next = ST_IDLE;
                end else if (timed_out) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Bus strobes decode straight from state flops, so reset drops them immediately.
    always_comb begin
        MEM_REQ    = (state_reg == ST_LOAD_WAIT) || (state_reg == ST_STORE_WAIT);
        MEM_WE     = (state_reg == ST_STORE_WAIT);
        DATA_VALID = (state_reg == ST_RESP);
        BUSY       = !is_idle || pend_valid_reg;
        MEM_ADDR   = bus_addr_reg;
        MEM_BE     = bus_be_reg;
        MEM_WDATA  = bus_wdata_reg;
        RDATA      = rdata_reg;
        MISALIGNED = mis_reg;
        BUS_ERR    = err_reg;
        OVERRUN    = overrun_reg;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scenario bench for load_store_unit: expected loads/writes queued at stimulus time,
// popped and compared when the DUT produces DATA_VALID or a bus write.
module tb_load_store_unit;

    localparam int AW  = 32;
    localparam int TMO = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    logic          CLK = 1'b0;
    logic          RES = 1'b1;
    logic          DATA_REQ = 1'b0;
    logic          DATA_WRITE_ENABLE = 1'b0;
    logic [2:0]    FUNCT3 = 3'b000;
    logic [AW-1:0] ADDR = '0;
    logic [31:0]   WDATA = '0;
    logic          MEM_ACK = 1'b0;
    logic [31:0]   MEM_RDATA = '0;
    logic          DATA_VALID, BUSY, MISALIGNED, BUS_ERR, OVERRUN, MEM_REQ, MEM_WE;
    logic [31:0]   RDATA, MEM_WDATA;
    logic [AW-1:0] MEM_ADDR;
    logic [3:0]    MEM_BE;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_rd_q[$];
    wr_t         exp_wr_q[$];

    load_store_unit #(.TIMEOUT(TMO), .AW(AW)) dut (
        .CLK               (CLK),
        .RES               (RES),
        .DATA_REQ          (DATA_REQ),
        .DATA_WRITE_ENABLE (DATA_WRITE_ENABLE),
        .FUNCT3            (FUNCT3),
        .ADDR              (ADDR),
        .WDATA             (WDATA),
        .DATA_VALID        (DATA_VALID),
        .RDATA             (RDATA),
        .BUSY              (BUSY),
        .MISALIGNED        (MISALIGNED),
        .BUS_ERR           (BUS_ERR),
        .OVERRUN           (OVERRUN),
        .MEM_REQ           (MEM_REQ),
        .MEM_WE            (MEM_WE),
        .MEM_ADDR          (MEM_ADDR),
        .MEM_BE            (MEM_BE),
        .MEM_WDATA         (MEM_WDATA),
        .MEM_ACK           (MEM_ACK),
        .MEM_RDATA         (MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    task automatic test_reset();
        logic [31:0] outs;
        #2 RES = 1'b0;
        repeat (2) @(negedge CLK);
        outs = {25'd0, DATA_VALID, BUSY, MISALIGNED, BUS_ERR, OVERRUN, MEM_REQ, MEM_WE};
        n_total++;
        if (outs !== 32'd0) $display("FAIL reset_flags: got %h expected %h", outs, 32'd0);
        else n_pass++;
        n_total++;
        if (RDATA !== 32'd0) $display("FAIL reset_rdata: got %h expected %h", RDATA, 32'd0);
        else n_pass++;
        n_total++;
        if ({MEM_ADDR, MEM_BE, MEM_WDATA} !== 68'd0)
            $display("FAIL reset_bus: got %h/%h/%h expected 0/0/0", MEM_ADDR, MEM_BE, MEM_WDATA);
        else n_pass++;
        RES = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_load_word();
        logic [31:0] exp;
        DATA_REQ = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h100;
        exp_rd_q.push_back(32'hDEADBEEF);
        @(negedge CLK);
        n_total++;
        if ({MEM_REQ, MEM_WE, MEM_BE} !== 6'b10_1111)
            $display("FAIL lw_req: got req=%b we=%b be=%b expected 1/0/1111", MEM_REQ, MEM_WE, MEM_BE);
        else n_pass++;
        n_total++;
        if (MEM_ADDR !== 32'h100) $display("FAIL lw_addr: got %h expected %h", MEM_ADDR, 32'h100);
        else n_pass++;
        repeat (3) @(negedge CLK);
        n_total++;
        if (MEM_REQ !== 1'b1 || DATA_VALID !== 1'b0)
            $display("FAIL lw_wait: got req=%b valid=%b expected 1/0", MEM_REQ, DATA_VALID);
        else n_pass++;
        MEM_ACK = 1'b1; MEM_RDATA = 32'hDEADBEEF;
        @(negedge CLK);
        MEM_ACK = 1'b0; MEM_RDATA = 32'h0;
        exp = (exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : 32'hx;
        n_total++;
        if (DATA_VALID !== 1'b1 || RDATA !== exp)
            $display("FAIL lw_data: got valid=%b rdata=%h expected 1/%h", DATA_VALID, RDATA, exp);
        else n_pass++;
        DATA_REQ = 1'b0;
        @(negedge CLK);
        n_total++;
        if (DATA_VALID !== 1'b0 || MEM_REQ !== 1'b0)
            $display("FAIL lw_pulse: got valid=%b req=%b expected 0/0", DATA_VALID, MEM_REQ);
        else n_pass++;
    endtask

    task automatic test_store_half();
        wr_t exp;
        int  valid_seen;
        valid_seen = 0;
        DATA_WRITE_ENABLE = 1'b1; FUNCT3 = 3'b001; ADDR = 32'h206; WDATA = 32'h0000ABCD;
        exp_wr_q.push_back('{addr: 32'h204, be: 4'b1100, data: 32'hABCDABCD});
        @(negedge CLK);
        DATA_WRITE_ENABLE = 1'b0; WDATA = 32'h0;
        exp = (exp_wr_q.size() != 0) ? exp_wr_q.pop_front() : 'x;
        n_total++;
        if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b1)
            $display("FAIL sh_req: got req=%b we=%b expected 1/1", MEM_REQ, MEM_WE);
        else n_pass++;
        n_total++;
        if ({MEM_ADDR, MEM_BE, MEM_WDATA} !== exp)
            $display("FAIL sh_bus: got %h/%b/%h expected %h/%b/%h",
                     MEM_ADDR, MEM_BE, MEM_WDATA, exp.addr, exp.be, exp.data);
        else n_pass++;
        valid_seen += int'(DATA_VALID);
        MEM_ACK = 1'b1;
        @(negedge CLK);
        MEM_ACK = 1'b0;
        valid_seen += int'(DATA_VALID);
        n_total++;
        if (MEM_REQ !== 1'b0 || BUSY !== 1'b0)
            $display("FAIL sh_done: got req=%b busy=%b expected 0/0", MEM_REQ, BUSY);
        else n_pass++;
        @(negedge CLK);
        valid_seen += int'(DATA_VALID);
        n_total++;
        if (valid_seen != 0) $display("FAIL sh_no_valid: got %0d valid cycles expected 0", valid_seen);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        logic [31:0] exp;
        DATA_REQ = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h101;
        exp_rd_q.push_back(32'h0);
        @(negedge CLK);
        exp = (exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : 32'hx;
        n_total++;
        if ({MEM_REQ, MISALIGNED, DATA_VALID} !== 3'b011)
            $display("FAIL mis_lw: got req=%b mis=%b valid=%b expected 0/1/1", MEM_REQ, MISALIGNED, DATA_VALID);
        else n_pass++;
        n_total++;
        if (RDATA !== exp) $display("FAIL mis_lw_rdata: got %h expected %h", RDATA, exp);
        else n_pass++;
        DATA_REQ = 1'b0;
        @(negedge CLK);
        n_total++;
        if (MISALIGNED !== 1'b0 || DATA_VALID !== 1'b0)
            $display("FAIL mis_pulse: got mis=%b valid=%b expected 0/0", MISALIGNED, DATA_VALID);
        else n_pass++;
        DATA_WRITE_ENABLE = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h202; WDATA = 32'h12345678;
        @(negedge CLK);
        DATA_WRITE_ENABLE = 1'b0;
        n_total++;
        if ({MEM_REQ, MISALIGNED, BUSY} !== 3'b010)
            $display("FAIL mis_sw: got req=%b mis=%b busy=%b expected 0/1/0", MEM_REQ, MISALIGNED, BUSY);
        else n_pass++;
        @(negedge CLK);
        n_total++;
        if (MEM_REQ !== 1'b0) $display("FAIL mis_sw_nobus: got req=%b expected 0", MEM_REQ);
        else n_pass++;
    endtask

    task automatic test_pending_overrun();
        wr_t exp;
        DATA_WRITE_ENABLE = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h300; WDATA = 32'h11111111;
        exp_wr_q.push_back('{addr: 32'h300, be: 4'b1111, data: 32'h11111111});
        @(negedge CLK);
        FUNCT3 = 3'b000; ADDR = 32'h305; WDATA = 32'h000000AB;
        exp_wr_q.push_back('{addr: 32'h304, be: 4'b0010, data: 32'hABABABAB});
        @(negedge CLK);
        n_total++;
        if (OVERRUN !== 1'b0) $display("FAIL ovr_early: got %b expected 0", OVERRUN);
        else n_pass++;
        FUNCT3 = 3'b010; ADDR = 32'h400; WDATA = 32'h44444444;
        @(negedge CLK);
        DATA_WRITE_ENABLE = 1'b0;
        n_total++;
        if (OVERRUN !== 1'b1 || BUSY !== 1'b1)
            $display("FAIL ovr_set: got ovr=%b busy=%b expected 1/1", OVERRUN, BUSY);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            exp = (exp_wr_q.size() != 0) ? exp_wr_q.pop_front() : 'x;
            n_total++;
            if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b1 || {MEM_ADDR, MEM_BE, MEM_WDATA} !== exp)
                $display("FAIL ovr_write%0d: got req=%b we=%b %h/%b/%h expected 1/1 %h/%b/%h", k,
                         MEM_REQ, MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA, exp.addr, exp.be, exp.data);
            else n_pass++;
            MEM_ACK = 1'b1;
            @(negedge CLK);
            MEM_ACK = 1'b0;
            if (k == 0) begin
                n_total++;
                if (MEM_REQ !== 1'b0 || BUSY !== 1'b1)
                    $display("FAIL ovr_gap: got req=%b busy=%b expected 0/1", MEM_REQ, BUSY);
                else n_pass++;
                @(negedge CLK);
            end
        end
        repeat (2) @(negedge CLK);
        n_total++;
        if ({MEM_REQ, BUSY, OVERRUN} !== 3'b001)
            $display("FAIL ovr_drop: got req=%b busy=%b ovr=%b expected 0/0/1", MEM_REQ, BUSY, OVERRUN);
        else n_pass++;
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3_tab[6]   = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b001};
        logic [31:0] addr_tab[6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100};
        logic [31:0] res_tab[6]  = '{32'hFFFFFF80, 32'h00000080, 32'h00008011,
                                     32'hFFFF8011, 32'h00000033, 32'h00002233};
        logic [31:0] exp;
        for (int i = 0; i < 6; i++) begin
            DATA_REQ = 1'b1; FUNCT3 = f3_tab[i]; ADDR = addr_tab[i];
            exp_rd_q.push_back(res_tab[i]);
            @(negedge CLK);
            MEM_ACK = 1'b1; MEM_RDATA = 32'h80112233;
            @(negedge CLK);
            MEM_ACK = 1'b0; MEM_RDATA = 32'h0;
            exp = (exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : 32'hx;
            n_total++;
            if (DATA_VALID !== 1'b1 || RDATA !== exp)
                $display("FAIL ext_%0d f3=%b addr=%h: got valid=%b rdata=%h expected 1/%h",
                         i, f3_tab[i], addr_tab[i], DATA_VALID, RDATA, exp);
            else n_pass++;
            DATA_REQ = 1'b0;
            @(negedge CLK);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] exp;
        int          req_cycles;
        req_cycles = 0;
        DATA_REQ = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h500;
        exp_rd_q.push_back(32'h0);
        for (int i = 0; i < TMO; i++) begin
            @(negedge CLK);
            req_cycles += int'(MEM_REQ);
        end
        n_total++;
        if (req_cycles != TMO) $display("FAIL tmo_req_cycles: got %0d expected %0d", req_cycles, TMO);
        else n_pass++;
        @(negedge CLK);
        exp = (exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : 32'hx;
        n_total++;
        if ({MEM_REQ, BUS_ERR, DATA_VALID} !== 3'b011 || RDATA !== exp)
            $display("FAIL tmo_resp: got req=%b err=%b valid=%b rdata=%h expected 0/1/1/%h",
                     MEM_REQ, BUS_ERR, DATA_VALID, RDATA, exp);
        else n_pass++;
        DATA_REQ = 1'b0;
        @(negedge CLK);
        n_total++;
        if (BUS_ERR !== 1'b0) $display("FAIL tmo_pulse: got %b expected 0", BUS_ERR);
        else n_pass++;
        MEM_ACK = 1'b1; MEM_RDATA = 32'hCAFEF00D;
        @(negedge CLK);
        MEM_ACK = 1'b0;
        n_total++;
        if ({MEM_REQ, DATA_VALID, BUSY} !== 3'b000 || RDATA !== 32'h0)
            $display("FAIL late_ack: got req=%b valid=%b busy=%b rdata=%h expected 0/0/0/0",
                     MEM_REQ, DATA_VALID, BUSY, RDATA);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        DATA_REQ = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h600;
        @(negedge CLK);
        n_total++;
        if (MEM_REQ !== 1'b1) $display("FAIL ares_req: got %b expected 1", MEM_REQ);
        else n_pass++;
        #1 RES = 1'b0;
        #1;
        n_total++;
        if ({MEM_REQ, OVERRUN, BUSY} !== 3'b000)
            $display("FAIL ares_clear: got req=%b ovr=%b busy=%b expected 0/0/0", MEM_REQ, OVERRUN, BUSY);
        else n_pass++;
        DATA_REQ = 1'b0;
        @(negedge CLK);
        RES = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_half();
        test_misaligned();
        test_pending_overrun();
        test_load_ext();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Data-side memory interface directly downstream of the core control FSM. It consumes the control block's DATA_REQ (load, level-held until DATA_VALID) and DATA_WRITE_ENABLE (store, one-cycle pulse in WB), and drives a simple req/ack word-addressed data bus. It performs byte-lane steering, load sign/zero extension, misalignment detection, posted stores with a one-entry pending slot, and a bus timeout. DATA_VALID and RDATA return to the control FSM and register-file writeback mux.

Parameters:
TIMEOUT, 16, max cycles MEM_REQ may wait for MEM_ACK; 0 disables timeout.
AW, 32, byte address width.

Ports:
CLK  in  1  clock, all state on rising edge.
RES  in  1  reset, asynchronous, active-low.
DATA_REQ  in  1  load request from ctrl; level, held until DATA_VALID seen.
DATA_WRITE_ENABLE  in  1  store request from ctrl; single-cycle pulse.
FUNCT3  in  3  instr[14:12]: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
ADDR  in  AW  byte address (rs1+imm), valid while request high.
WDATA  in  32  store data (rs2), valid with DATA_WRITE_ENABLE.
DATA_VALID  out  1  one-cycle load-complete pulse.
RDATA  out  32  extended load result, held until next load completes.
BUSY  out  1  high whenever state != IDLE or pending slot full.
MISALIGNED  out  1  one-cycle pulse on misaligned or illegal-FUNCT3 access.
BUS_ERR  out  1  one-cycle pulse on timeout.
OVERRUN  out  1  sticky; store arrived with pending slot full; cleared by reset only.
MEM_REQ  out  1  bus request, registered.
MEM_WE  out  1  1 = write.
MEM_ADDR  out  AW  word-aligned address (ADDR[1:0] forced 00).
MEM_BE  out  4  byte enables.
MEM_WDATA  out  32  lane-replicated store data.
MEM_ACK  in  1  bus completion; MEM_RDATA valid same cycle.
MEM_RDATA  in  32  read word.

Behaviour:
- Reset (RES=0, async): state IDLE; all outputs 0, RDATA=0, pending slot empty, timeout counter 0, OVERRUN=0.
- States: IDLE, LOAD_WAIT, STORE_WAIT, RESP.
- IDLE priority: pending store > DATA_WRITE_ENABLE > DATA_REQ. Simultaneous store+load: store first; load waits (DATA_REQ is level).
- Alignment check: halfword needs ADDR[0]=0, word needs ADDR[1:0]=00; FUNCT3 011/110/111 illegal (store: also 1xx illegal). Failed check: no bus cycle, MISALIGNED pulses next cycle; load -> RESP with RDATA=0; store -> discarded, back to IDLE.
- Load: IDLE sees DATA_REQ -> LOAD_WAIT, MEM_REQ=1, MEM_WE=0, MEM_BE=1111. Minimum latency: DATA_REQ in cycle 0, MEM_REQ cycle 1, MEM_ACK cycle 1 -> DATA_VALID cycle 2.
- On MEM_ACK in LOAD_WAIT: MEM_REQ drops next cycle; select lane by ADDR[1:0] (byte) or ADDR[1] (half); sign-extend LB/LH, zero-extend LBU/LHU; register into RDATA; -> RESP.
- RESP: DATA_VALID=1 for exactly one cycle, then IDLE. DATA_REQ still high during RESP is not re-accepted.
- Store: pulse captured (addr, data, funct3) -> STORE_WAIT, MEM_WE=1; MEM_BE = 0001<<ADDR[1:0] (SB), 0011<<{ADDR[1],0} (SH), 1111 (SW); MEM_WDATA = byte x4 / half x2 / word. MEM_ACK -> IDLE. No DATA_VALID for stores.
- Store pulse while not in IDLE: written to pending slot; if slot full, dropped, OVERRUN set.
- MEM_REQ/MEM_WE/MEM_ADDR/MEM_BE/MEM_WDATA stable while MEM_REQ high.
- Timeout: counter counts cycles with MEM_REQ high and no ACK; at TIMEOUT: MEM_REQ drops, BUS_ERR pulses; load -> RESP with RDATA=0; store -> IDLE. Late MEM_ACK while IDLE ignored.

Decomposition:
- Shared include riscv_isa_defines.v: FUNCT3 load/store codes (LB..LHU, SB..SW) and LSU state encodings (one-hot, 4 bits).
- Sub-module lsu_align: combinational byte-enable/write-lane generation, read-lane selection, extension, alignment check. FSM, pending slot, timeout counter in load_store_unit.

Test Plan:
- LW ADDR=0x100, MEM_RDATA=0xDEADBEEF, ACK after 3 wait cycles -> DATA_VALID one cycle, RDATA=0xDEADBEEF, MEM_ADDR=0x100.
- LB ADDR=0x103, MEM_RDATA=0x80112233 -> RDATA=0xFFFFFF80; LBU same -> 0x00000080; LHU ADDR=0x102 -> 0x00008011.
- SH ADDR=0x206, WDATA=0x0000ABCD -> MEM_WE=1, MEM_ADDR=0x204, MEM_BE=1100, MEM_WDATA=0xABCDABCD; no DATA_VALID.
- LW ADDR=0x101 -> no MEM_REQ, MISALIGNED pulse, DATA_VALID with RDATA=0.
- Store pulse then second store while first unacked, third while slot full -> two bus writes in order, OVERRUN=1.
- TIMEOUT=4, load with MEM_ACK never -> MEM_REQ high 4 cycles, BUS_ERR pulse, DATA_VALID with RDATA=0; RES low mid-LOAD_WAIT -> MEM_REQ=0 immediately.
